// File: rtl/mnist_pkg.sv
// Shared constants and loader state encoding for the MNIST image path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mnist_pkg;

    localparam int N_PIX   = 784;
    localparam int PIX_W   = 8;
    localparam int IMG_W   = N_PIX * PIX_W;   // 6272
    localparam int DIGIT_W = 4;

    // Digit reported when the classifier never answers
    localparam logic [DIGIT_W-1:0] DIGIT_TIMEOUT = 4'hF;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        START  = 2'd1,
        WAIT   = 2'd2,
        RESULT = 2'd3
    } ldr_state_e;

endpackage

// File: rtl/img_stream_loader_if.sv
// Bundle of the loader's pixel stream, result handshake, status and mnist_top signals.
// Latency: n/a (wiring only).
// Backpressure: pix_ready throttles the pixel source; res_ready throttles the result.
//
// Modports:
//   master - environment side: byte source, result consumer and mnist_top
//            (drives pix_in/pix_valid, res_ready, done, pred_digit)
//   slave  - img_stream_loader itself
interface img_stream_loader_if #(
    parameter int N_PIX = mnist_pkg::N_PIX,
    parameter int PIX_W = mnist_pkg::PIX_W,
    parameter int CNT_W = 20
) ();

    // pixel stream
    logic [PIX_W-1:0]       pix_in;
    logic                   pix_valid;
    logic                   pix_ready;
    // mnist_top side
    logic [N_PIX*PIX_W-1:0] img_data;
    logic                   start;
    logic                   done;
    logic [3:0]             pred_digit;
    // result handshake and status
    logic [3:0]             res_digit;
    logic                   res_valid;
    logic                   res_ready;
    logic                   busy;
    logic                   timeout_err;
    logic [CNT_W-1:0]       cyc_count;

    modport master (
        output pix_in, pix_valid, res_ready, done, pred_digit,
        input  pix_ready, img_data, start, res_digit, res_valid,
               busy, timeout_err, cyc_count
    );

    modport slave (
        input  pix_in, pix_valid, res_ready, done, pred_digit,
        output pix_ready, img_data, start, res_digit, res_valid,
               busy, timeout_err, cyc_count
    );

endinterface

// File: rtl/img_stream_loader_pix_shift_buf.sv
// Indexed image buffer: writes one pixel per enabled cycle into the next slot.
// Latency: a written byte appears on img_data_o the cycle after wr_en_i.
// Backpressure: none internally; the caller gates wr_en_i with its own ready.
//
// Ports:
//   clk, rst     - clock, synchronous active-high reset (clears image and index)
//   wr_en_i      - accept pix_i into slot idx this cycle
//   pix_i        - pixel byte
//   img_data_o   - flattened image, pixel i at [i*PIX_W +: PIX_W]
//   last_o       - current index is the final slot (next write completes the image)
module pix_shift_buf #(
    parameter int N_PIX = mnist_pkg::N_PIX,
    parameter int PIX_W = mnist_pkg::PIX_W,
    parameter int IDX_W = $clog2(N_PIX)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en_i,
    input  logic [PIX_W-1:0]       pix_i,
    output logic [N_PIX*PIX_W-1:0] img_data_o,
    output logic                   last_o
);

    logic [N_PIX*PIX_W-1:0] img_q;
    logic [IDX_W-1:0]       idx_q, idx_d;

    assign last_o     = (idx_q == IDX_W'(N_PIX - 1));
    assign img_data_o = img_q;

    // Index wraps to slot 0 after the last pixel so the next image overwrites in order
    always_comb begin
        idx_d = idx_q;
        if (wr_en_i) begin
            idx_d = last_o ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            img_q <= '0;
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
            if (wr_en_i) begin
                img_q[idx_q*PIX_W +: PIX_W] <= pix_i;
            end
        end
    end

endmodule

// File: rtl/img_stream_loader.sv
// Host-side initiator for mnist_top: loads a streamed image, starts inference, returns the digit.
// Latency: start one cycle after the last pixel; result one cycle after done (or after the timeout).
// Backpressure: pix_ready only in LOAD; the result is held until res_ready, stalling new pixels.
//
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   bus       - img_stream_loader_if.slave: pixel stream, mnist_top img_data/start/done/pred_digit,
//               result handshake, busy, timeout_err, cyc_count
// Build option IMG_LOADER_CYCLE_COUNT_EN: when defined, cyc_count reports inference latency
// (cycles after start through the done cycle, TIMEOUT_CYC on timeout); otherwise it reads 0.
module img_stream_loader
    import mnist_pkg::*;
#(
    parameter int N_PIX       = mnist_pkg::N_PIX,
    parameter int PIX_W       = mnist_pkg::PIX_W,
    parameter int TIMEOUT_CYC = 100000,
    parameter int CNT_W       = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    img_stream_loader_if.slave   bus
);

    ldr_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DIGIT_W-1:0]     res_digit_q, res_digit_d;
    logic                   res_valid_q, res_valid_d;
    logic                   timeout_err_q, timeout_err_d;

    logic                   pix_ready;
    logic                   start;
    logic                   pix_acc;
    logic                   pix_last;
    logic                   wait_done;
    logic                   wait_tmo;
    logic [N_PIX*PIX_W-1:0] img_data;

    assign pix_acc   = pix_ready && bus.pix_valid;
    assign wait_done = (state_q == WAIT) && bus.done;
    assign wait_tmo  = (state_q == WAIT) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    // Buffer writes only happen in LOAD, so img_data is frozen from START until RESULT exits
    pix_shift_buf #(
        .N_PIX (N_PIX),
        .PIX_W (PIX_W)
    ) u_pix_buf (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (pix_acc),
        .pix_i      (bus.pix_in),
        .img_data_o (img_data),
        .last_o     (pix_last)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        res_digit_d   = res_digit_q;
        res_valid_d   = res_valid_q;
        timeout_err_d = timeout_err_q;
        pix_ready     = 1'b0;
        start         = 1'b0;

        unique case (state_q)
            LOAD: begin
                pix_ready = 1'b1;
                if (bus.pix_valid) begin
                    timeout_err_d = 1'b0;
                    if (pix_last) begin
                        state_d = START;
                    end
                end
            end
            START: begin
                start   = 1'b1;
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // done takes priority over a timeout landing on the same cycle
                if (wait_done) begin
                    res_digit_d = bus.pred_digit;
                    res_valid_d = 1'b1;
                    state_d     = RESULT;
                end else if (wait_tmo) begin
                    res_digit_d   = DIGIT_TIMEOUT;
                    timeout_err_d = 1'b1;
                    res_valid_d   = 1'b1;
                    state_d       = RESULT;
                end
            end
            RESULT: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= LOAD;
            cnt_q         <= '0;
            res_digit_q   <= '0;
            res_valid_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            res_digit_q   <= res_digit_d;
            res_valid_q   <= res_valid_d;
            timeout_err_q <= timeout_err_d;
        end
    end

`ifdef IMG_LOADER_CYCLE_COUNT_EN
    logic [CNT_W-1:0] cyc_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_count_q <= '0;
        end else if (wait_done) begin
            cyc_count_q <= cnt_q + 1'b1;
        end else if (wait_tmo) begin
            cyc_count_q <= CNT_W'(TIMEOUT_CYC);
        end
    end

    assign bus.cyc_count = cyc_count_q;
`else
    assign bus.cyc_count = '0;
`endif

    assign bus.pix_ready   = pix_ready;
    assign bus.start       = start;
    assign bus.img_data    = img_data;
    assign bus.res_digit   = res_digit_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.busy        = (state_q != LOAD);

endmodule

// File: tb/tb_img_stream_loader.sv
// Directed bench for img_stream_loader acting as byte source, mnist_top stub and result consumer.
// Latency: n/a.
// Backpressure: exercises held res_ready and random pix_valid gaps.
module tb_img_stream_loader;
    import mnist_pkg::*;

    localparam int TMO   = 50;
    localparam int CNT_W = 20;
`ifdef IMG_LOADER_CYCLE_COUNT_EN
    localparam int CYC_EN = 1;
`else
    localparam int CYC_EN = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    img_stream_loader_if #(.N_PIX(N_PIX), .PIX_W(PIX_W), .CNT_W(CNT_W)) bif ();

    img_stream_loader #(
        .N_PIX       (N_PIX),
        .PIX_W       (PIX_W),
        .TIMEOUT_CYC (TMO),
        .CNT_W       (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    typedef struct {
        logic [3:0]       digit;
        logic             terr;
        logic [CNT_W-1:0] cyc;
    } res_t;

    int         checks   = 0;
    int         failures = 0;
    logic [IMG_W-1:0] img_exp = '0;
    res_t       sb[$];

    function automatic logic [CNT_W-1:0] cyc_exp(int n);
        return CNT_W'(n * CYC_EN);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_img(string tag);
        int bad;
        checks++;
        assert (bif.img_data === img_exp) else begin
            failures++;
            bad = -1;
            for (int s = N_PIX - 1; s >= 0; s--) begin
                if (bif.img_data[s*PIX_W +: PIX_W] !== img_exp[s*PIX_W +: PIX_W]) bad = s;
            end
            if (bad < 0) bad = 0;
            $error("FAIL %s slot=%0d observed=%0h expected=%0h", tag, bad,
                   bif.img_data[bad*PIX_W +: PIX_W], img_exp[bad*PIX_W +: PIX_W]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst            = 1'b1;
        bif.pix_valid  = 1'b0;
        bif.pix_in     = '0;
        bif.res_ready  = 1'b0;
        bif.done       = 1'b0;
        bif.pred_digit = '0;
        @(negedge clk);
        rst     = 1'b0;
        img_exp = '0;
        sb.delete();
        chk_img("rst_img_data");
        chk("rst_start",       32'(bif.start),       32'd0);
        chk("rst_res_valid",   32'(bif.res_valid),   32'd0);
        chk("rst_res_digit",   32'(bif.res_digit),   32'd0);
        chk("rst_busy",        32'(bif.busy),        32'd0);
        chk("rst_timeout_err", 32'(bif.timeout_err), 32'd0);
        chk("rst_cyc_count",   32'(bif.cyc_count),   32'd0);
        chk("rst_pix_ready",   32'(bif.pix_ready),   32'd1);
    endtask

    // Streams npix pixels (i+base)&FF; rnd gives a 50% pix_valid duty
    task automatic send_image(int npix, int base, bit rnd);
        int i = 0;
        int guard = 0;
        bit bad_start = 1'b0;
        bit terr_checked = 1'b0;
        while (i < npix && guard < 20000) begin
            @(negedge clk);
            guard++;
            if (i == 1 && !terr_checked) begin
                chk("terr_clear_on_accept", 32'(bif.timeout_err), 32'd0);
                terr_checked = 1'b1;
            end
            if (bif.start) bad_start = 1'b1;
            bif.pix_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bif.pix_in    = 8'((i + base) & 255);
            if (bif.pix_valid && bif.pix_ready) begin
                img_exp[i*PIX_W +: PIX_W] = bif.pix_in;
                i++;
            end
        end
        @(negedge clk);
        bif.pix_valid = 1'b0;
        chk("load_progress", 32'(i), 32'(npix));
        chk("no_early_start", 32'(bad_start), 32'd0);
        if (npix == N_PIX) begin
            chk("start_after_last", 32'(bif.start),     32'd1);
            chk("start_pix_ready",  32'(bif.pix_ready), 32'd0);
            chk("start_busy",       32'(bif.busy),      32'd1);
            chk_img("img_data");
        end
    endtask

    // mnist_top stub: raises done on WAIT cycle `delay` (0 = never); result expected at negedge exp_k
    task automatic stub_wait(int delay, logic [3:0] digit, int exp_k);
        int   lat = -1;
        int   start_pulses = 0;
        bit   rdy_bad = 1'b0;
        res_t e;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (bif.res_valid) begin
                lat = k;
                break;
            end
            if (bif.start) start_pulses++;
            if (bif.pix_ready) rdy_bad = 1'b1;
            bif.done       = (k == delay);
            bif.pred_digit = digit;
        end
        bif.done = 1'b0;
        chk("result_latency",   32'(lat),          32'(exp_k));
        chk("single_start",     32'(start_pulses), 32'd0);
        chk("wait_pix_ready",   32'(rdy_bad),      32'd0);
        e = sb.pop_front();
        chk("res_digit",   32'(bif.res_digit),   32'(e.digit));
        chk("timeout_err", 32'(bif.timeout_err), 32'(e.terr));
        chk("cyc_count",   32'(bif.cyc_count),   32'(e.cyc));
        chk("result_busy", 32'(bif.busy),        32'd1);
    endtask

    task automatic take_result(int hold, logic [3:0] exp_digit);
        bit unstable = 1'b0;
        bit accepted = 1'b0;
        repeat (hold) begin
            @(negedge clk);
            bif.res_ready = 1'b0;
            bif.pix_valid = 1'b1;
            bif.pix_in    = 8'hAA;
            if (bif.res_valid !== 1'b1 || bif.res_digit !== exp_digit) unstable = 1'b1;
            if (bif.pix_ready) accepted = 1'b1;
        end
        if (hold > 0) begin
            chk("hold_result_stable", 32'(unstable), 32'd0);
            chk("hold_no_accept",     32'(accepted), 32'd0);
        end
        @(negedge clk);
        bif.pix_valid = 1'b0;
        bif.res_ready = 1'b1;
        chk("res_valid_at_hs", 32'(bif.res_valid), 32'd1);
        @(negedge clk);
        bif.res_ready = 1'b0;
        chk("res_valid_after_hs", 32'(bif.res_valid), 32'd0);
        chk("busy_after_hs",      32'(bif.busy),      32'd0);
        chk("ready_after_hs",     32'(bif.pix_ready), 32'd1);
    endtask

    initial begin
        bif.pix_valid  = 1'b0;
        bif.pix_in     = '0;
        bif.res_ready  = 1'b0;
        bif.done       = 1'b0;
        bif.pred_digit = '0;
        do_reset();

        // back-to-back image, done 10 cycles after start
        send_image(N_PIX, 0, 1'b0);
        sb.push_back('{digit: 4'd6, terr: 1'b0, cyc: cyc_exp(10)});
        stub_wait(10, 4'd6, 11);
        take_result(0, 4'd6);

        // 50% valid duty
        send_image(N_PIX, 17, 1'b1);
        sb.push_back('{digit: 4'd4, terr: 1'b0, cyc: cyc_exp(10)});
        stub_wait(10, 4'd4, 11);
        take_result(0, 4'd4);

        // classifier never answers
        send_image(N_PIX, 50, 1'b0);
        sb.push_back('{digit: 4'hF, terr: 1'b1, cyc: cyc_exp(TMO)});
        stub_wait(0, 4'd5, TMO + 1);
        take_result(0, 4'hF);
        chk("terr_held_after_hs", 32'(bif.timeout_err), 32'd1);

        // result held unread for 20 cycles with pixels offered
        send_image(N_PIX, 99, 1'b0);
        sb.push_back('{digit: 4'd7, terr: 1'b0, cyc: cyc_exp(5)});
        stub_wait(5, 4'd7, 6);
        take_result(20, 4'd7);

        send_image(N_PIX, 123, 1'b1);
        sb.push_back('{digit: 4'd3, terr: 1'b0, cyc: cyc_exp(10)});
        stub_wait(10, 4'd3, 11);
        take_result(0, 4'd3);

        // reset in the middle of a load, then a fresh image
        send_image(400, 200, 1'b0);
        do_reset();
        send_image(N_PIX, 77, 1'b0);
        sb.push_back('{digit: 4'd9, terr: 1'b0, cyc: cyc_exp(10)});
        stub_wait(10, 4'd9, 11);
        take_result(0, 4'd9);

        // done on the same cycle the timeout would fire
        send_image(N_PIX, 5, 1'b0);
        sb.push_back('{digit: 4'd2, terr: 1'b0, cyc: cyc_exp(TMO)});
        stub_wait(TMO, 4'd2, TMO + 1);
        take_result(0, 4'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/img_stream_loader.md
Name: img_stream_loader

Overview:
- Host-side initiator for `mnist_top`: it performs in hardware the job a bench does in simulation.
- Accepts pixels one byte per cycle over a valid/ready stream and assembles the flattened 784×8-bit `img_data` vector.
- Pulses `start`, waits for `done`, captures `pred_digit`, and returns it over a valid/ready result handshake.
- Sits between the I/O front end (UART/DMA byte source) and `mnist_top`.

Parameters:
- N_PIX, 784, pixels per image
- PIX_W, 8, bits per pixel
- TIMEOUT_CYC, 100000, max cycles in WAIT before abort (default 1 ms at 100 MHz)
- CNT_W, 20, width of the cycle/timeout counter; must hold TIMEOUT_CYC

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  reset; synchronous, active-high
- pix_in  in  PIX_W  pixel byte
- pix_valid  in  1  pixel present
- pix_ready  out  1  loader accepts a pixel this cycle
- img_data  out  N_PIX*PIX_W  flattened image to `mnist_top`; pixel i at [i*PIX_W +: PIX_W]
- start  out  1  one-cycle inference start to `mnist_top`
- done  in  1  inference complete from `mnist_top`
- pred_digit  in  4  classification from `mnist_top`
- res_digit  out  4  captured result (4'hF on timeout)
- res_valid  out  1  result available
- res_ready  in  1  consumer takes result
- busy  out  1  high in START/WAIT/RESULT
- timeout_err  out  1  last result was a timeout
- cyc_count  out  CNT_W  inference latency of last image

Behaviour:
- Reset value of every output and register is 0: `img_data`, `start`, `res_*`, `busy`, `timeout_err`, `cyc_count`, pixel index. State goes to LOAD.
- Reset mid-operation discards partial image and any pending result.

LOAD:
- `pix_ready`=1.
- A pixel is accepted on a cycle with `pix_valid` && `pix_ready`; it is written to slot `pix_idx`, then `pix_idx`++.
- Accepting the pixel when `pix_idx`==N_PIX-1 moves to START next cycle and clears `pix_idx`.
- The first pixel accepted after a result clears `timeout_err`.

START:
- `start`=1 for exactly this one cycle; `pix_ready`=0.
- `done` is ignored in this state.
- Next state: WAIT; the counter is loaded to 0.

WAIT:
- `start`=0; counter increments each cycle.
- `done`=1 → `res_digit`<=`pred_digit`, `cyc_count`<=counter+1, `res_valid`<=1, go to RESULT.
- If the counter reaches TIMEOUT_CYC-1 with no `done` → `res_digit`<=4'hF, `timeout_err`<=1, `res_valid`<=1, go to RESULT.
- If `done` and the timeout occur on the same cycle, `done` wins.

RESULT:
- Hold `res_digit`/`res_valid` until `res_valid` && `res_ready`.
- On handshake: `res_valid`<=0 next cycle, go to LOAD.
- `pix_ready`=0 throughout, so no new pixels are accepted while a result is unread.

Timing and data rules:
- `img_data` is stable (no writes) from entry to START until exit from RESULT.
- Slots are overwritten in order in the next LOAD; there is no clear between images.
- Zero-bubble loading: 784 pixels accepted in 784 consecutive cycles when `pix_valid` is held high.
- `start` asserts the cycle after the last accepted pixel.

Optional Feature:
- Macro: IMG_LOADER_CYCLE_COUNT_EN.
- Defined: `cyc_count` reports cycles from the cycle after `start` through the cycle `done` is sampled, inclusive; on timeout it reports TIMEOUT_CYC.
- Undefined: `cyc_count` is tied to 0. The timeout counter still exists, but its value is not exported.

Decomposition:
- Shared package `mnist_pkg`:
  - constants N_PIX, PIX_W, IMG_W (=6272), DIGIT_W (=4), DIGIT_TIMEOUT (=4'hF)
  - state encoding typedef: LOAD, START, WAIT, RESULT
- Sub-module `pix_shift_buf`: the indexed 784-byte write buffer with index counter and last-pixel flag. The FSM, counter and result register stay in the top.

Test Plan:
- Stream pixels `i & 8'hFF` (i=0..783) back-to-back; stub `mnist_top` raises `done` 10 cycles after `start` with `pred_digit`=6.
  - Expect `img_data[i*8 +: 8]` = `i & 8'hFF`.
  - Expect exactly one `start` pulse, the cycle after pixel 783.
  - Expect `res_digit`=6, `cyc_count`=10 with macro on (0 with macro off).
- Drive `pix_valid` randomly at 50% duty:
  - Expect all 784 bytes placed correctly.
  - Expect `start` only after the 784th accept.
  - Expect `pix_ready`=0 from START until the result handshake.
- Stub never asserts `done`, with TIMEOUT_CYC=50:
  - Expect `res_valid` after 50 WAIT cycles, `res_digit`=4'hF, `timeout_err`=1.
  - Expect `timeout_err` to clear on the next accepted pixel.
- Hold `res_ready`=0 for 20 cycles while `pix_valid`=1:
  - Expect `res_digit`/`res_valid` stable and no pixels accepted.
  - After `res_ready` pulses, the next image loads and returns `pred_digit`=3 correctly.
- Assert `rst` for 1 cycle after 400 pixels, then send a full image:
  - Expect all outputs 0 after reset.
  - Expect the new image to occupy slots 0..783 and normal completion with `pred_digit`=9.
- Stub asserts `done` on the same cycle the counter hits TIMEOUT_CYC-1, with `pred_digit`=2:
  - Expect `res_digit`=2 and `timeout_err`=0.
